miriscv_int_ctrl: RTL and testbench

Interrupt controller between the 32 peripheral interrupt request lines and the miriscv core inside miriscv_top. It masks requests with the core's mie CSR value and selects one request. It raises a single interrupt to the core with a cause code, holds it until the core executes mret, then returns a one-cycle completion pulse to the served line on int_fin_o.

---
 rtl/miriscv_int_ctrl.sv | 155 +++++++++++++++
 tb/tb_miriscv_int_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/miriscv_int_ctrl.sv
// miriscv_int_ctrl: interrupt controller between the peripheral request lines
// and the miriscv core. It masks requests with mie, selects one, and raises int_o
// with a cause code until the core executes mret. It then pulses int_fin_o for
// one cycle on the line that was served.
//
// Build option: define INT_CTRL_RR_EN for round-robin arbitration. When it is
// undefined, the lowest eligible index always wins and the pointer logic is not
// compiled in.
module miriscv_int_ctrl #(
  parameter int N_IRQ = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] int_req_i,
  input  logic [31:0] mie_i,
  input  logic        mret_i,
  output logic        int_o,
  output logic [31:0] mcause_o,
  output logic [31:0] int_fin_o
);

  // Lines above N_IRQ never take part in arbitration.
  localparam logic [31:0] LINE_MASK =
    (N_IRQ >= 32) ? 32'hFFFF_FFFF : ((32'd1 << N_IRQ) - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_FIN   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        int_q, int_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] fin_q, fin_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] eligible;
  logic [4:0]  sel_idx;

`ifdef INT_CTRL_RR_EN
  logic [4:0]  ptr_q, ptr_d;

  // The first eligible line found when scanning upward from ptr, wrapping at N_IRQ.
  function automatic logic [4:0] pick_rr(input logic [31:0] elig,
                                         input logic [4:0]  ptr);
    logic [4:0] r;
    logic       found;
    int         j;
    r     = '0;
    found = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_IRQ) j = j - N_IRQ;
      if (!found && elig[5'(j)]) begin
        r     = 5'(j);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // The pointer value that follows a served index: (idx + 1) mod N_IRQ.
  function automatic logic [4:0] ptr_after(input logic [4:0] idx);
    if (int'(idx) >= N_IRQ - 1) return '0;
    return idx + 5'd1;
  endfunction
`else
  // The lowest set index. The loop scans downward so that the last hit is the lowest.
  function automatic logic [4:0] pick_fixed(input logic [31:0] elig);
    logic [4:0] r;
    r = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) r = 5'(i);
    end
    return r;
  endfunction
`endif

  // Masked request vector and the arbitration winner for this cycle.
  always_comb begin
    eligible = int_req_i & mie_i & LINE_MASK;
`ifdef INT_CTRL_RR_EN
    sel_idx  = pick_rr(eligible, ptr_q);
`else
    sel_idx  = pick_fixed(eligible);
`endif
  end

  // Next-state and next-output logic. idx and mcause stay frozen outside IDLE.
  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    mcause_d = mcause_q;
    fin_d    = '0;
    idx_d    = idx_q;
`ifdef INT_CTRL_RR_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          state_d  = ST_SERVE;
          idx_d    = sel_idx;
          int_d    = 1'b1;
          mcause_d = {1'b1, 26'b0, sel_idx};
        end
      end
      ST_SERVE: begin
        if (mret_i) begin
          state_d = ST_FIN;
          int_d   = 1'b0;
          fin_d   = 32'd1 << idx_q;
`ifdef INT_CTRL_RR_EN
          ptr_d   = ptr_after(idx_q);
`endif
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        int_d   = 1'b0;
      end
    endcase
  end

  // State and registered outputs. An asynchronous reset aborts service without a fin pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      int_q    <= 1'b0;
      mcause_q <= '0;
      fin_q    <= '0;
      idx_q    <= '0;
`ifdef INT_CTRL_RR_EN
      ptr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      int_q    <= int_d;
      mcause_q <= mcause_d;
      fin_q    <= fin_d;
      idx_q    <= idx_d;
`ifdef INT_CTRL_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  assign int_o     = int_q;
  assign mcause_o  = mcause_q;
  assign int_fin_o = fin_q;

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// Testbench for miriscv_int_ctrl. A driver acts as both the peripherals and the
// core. It pushes the expected service and fin events into queues. A monitor pops
// and compares them whenever the DUT raises int_o or pulses int_fin_o.
module tb_miriscv_int_ctrl;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] req;
  logic [31:0] mie;
  logic        mret;
  logic        irq;
  logic [31:0] mcause;
  logic [31:0] fin;

  miriscv_int_ctrl #(.N_IRQ(N)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .int_req_i (req),
    .mie_i     (mie),
    .mret_i    (mret),
    .int_o     (irq),
    .mcause_o  (mcause),
    .int_fin_o (fin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;
  int m_ptr    = 0;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;

  exp_t serve_q[$];
  exp_t fin_q[$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_err++;
    $display("FAIL %s: unexpected event, value %h (cycle %0d)", name, act, cyc);
  endfunction

  // Reference arbitration: the winner among the eligible lines.
  function automatic int pick(input logic [31:0] elig);
`ifdef INT_CTRL_RR_EN
    for (int k = 0; k < N; k++) begin
      if (elig[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (elig[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Monitor: compare every rise of int_o and every fin pulse with the queued expectations.
  logic        int_prev = 1'b0;
  logic [31:0] cur_cause = '0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      int_prev = 1'b0;
    end else begin
      if (irq && !int_prev) begin
        if (serve_q.size() == 0) unexpected("int_o_rise", mcause);
        else begin
          e = serve_q.pop_front();
          check("mcause", mcause, e.val);
          check("serve_cycle", 32'(cyc), 32'(e.cyc));
          cur_cause = e.val;
        end
      end else if (irq) begin
        check("mcause_hold", mcause, cur_cause);
      end
      if (fin != '0) begin
        if (fin_q.size() == 0) unexpected("int_fin", fin);
        else begin
          e = fin_q.pop_front();
          check("int_fin", fin, e.val);
          check("fin_cycle", 32'(cyc), 32'(e.cyc));
          check("int_o_in_fin", {31'b0, irq}, 32'h0);
        end
      end
      int_prev = irq;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete service. The caller guarantees that the controller is idle in the
  // current cycle and that req & mie is nonzero. On return the controller is idle
  // again and the served line has been cleared.
  task automatic serve_txn(input int max_hold, input logic [31:0] raise_mask,
                           input bit wild, output int idx);
    int hold;
    idx = pick(req & mie);
    serve_q.push_back('{32'h8000_0000 | 32'(idx), cyc + 1});
    step();
    req  = req | raise_mask;
    hold = int'($urandom_range(0, max_hold));
    for (int h = 0; h < hold; h++) begin
      if (wild) begin
        req = req | ($urandom & $urandom & $urandom);
        if ($urandom_range(0, 3) == 0) mie = ~($urandom & $urandom);
        if ($urandom_range(0, 5) == 0) req[idx] = 1'b0;
      end
      step();
    end
    mret = 1'b1;
    fin_q.push_back('{32'd1 << idx, cyc + 1});
    step();
    mret  = wild && ($urandom_range(0, 1) == 1);
    m_ptr = (idx + 1) % N;
    step();
    mret     = 1'b0;
    req[idx] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int idx;
    int prev;
    int waited;
    int j;
    rst_n = 1'b0;
    req   = '0;
    mie   = '0;
    mret  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("rst_int_o", {31'b0, irq}, 32'h0);
    check("rst_mcause", mcause, 32'h0);
    check("rst_int_fin", fin, 32'h0);

    // Stray mret pulses while idle.
    for (int k = 0; k < 3; k++) begin
      mret = 1'b1;
      step();
      mret = 1'b0;
      step();
    end
    check("stray_int_o", {31'b0, irq}, 32'h0);
    check("stray_mcause", mcause, 32'h0);
    check("stray_int_fin", fin, 32'h0);

    // Single request on line 3.
    req = 32'h0000_0008;
    mie = '1;
    serve_txn(2, '0, 1'b0, idx);
    repeat (4) step();

    // A request masked off for 100 cycles, then enabled.
    req = 32'h0000_0001;
    mie = '0;
    repeat (100) step();
    check("masked_int_o", {31'b0, irq}, 32'h0);
    mie = 32'h0000_0001;
    serve_txn(1, '0, 1'b0, idx);
    repeat (2) step();

    // Priority: bit 1 rises during the first service, then drain 1, 4, 31.
    req = 32'h8000_0011;
    mie = '1;
    serve_txn(2, 32'h0000_0002, 1'b0, idx);
    for (int k = 0; k < 3; k++) serve_txn(1, '0, 1'b0, idx);
    repeat (2) step();

    // Lines 0 and 5 held. Each is cleared on its fin and re-raised one cycle later.
    req  = 32'h0000_0021;
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      serve_txn(1, (prev >= 0) ? (32'd1 << prev) : 32'd0, 1'b0, idx);
      prev = idx;
    end
    req = '0;
    repeat (3) step();

    // Reset asserted between clock edges while in service.
    req = 32'h0000_0040;
    mie = '1;
    serve_q.push_back('{32'h8000_0000 | 32'(pick(req & mie)), cyc + 1});
    step();
    #6;
    rst_n = 1'b0;
    #1;
    check("midrst_int_o", {31'b0, irq}, 32'h0);
    check("midrst_mcause", mcause, 32'h0);
    check("midrst_int_fin", fin, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ptr = 0;
    serve_txn(2, '0, 1'b0, idx);

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 1) == 1) req = req | ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 2) == 0) mie = ~($urandom & $urandom);
      waited = 0;
      while ((req & mie) == '0) begin
        step();
        waited++;
        if (waited > 2) begin
          j      = int'($urandom_range(0, N - 1));
          req[j] = 1'b1;
          mie[j] = 1'b1;
        end
      end
      serve_txn(4, '0, 1'b1, idx);
    end

    req = '0;
    mie = '0;
    repeat (6) step();
    check("serve_queue_empty", 32'(serve_q.size()), 32'h0);
    check("fin_queue_empty", 32'(fin_q.size()), 32'h0);
    check("end_int_o", {31'b0, irq}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
